// File: rtl/digi_ota_array.sv
// Multi-channel clocked comparator: 2-flop input sync, programmable sample ticks, tie hold.
// Optional per-channel flip hysteresis is enabled by defining DIGI_OTA_HYST_EN.
module digi_ota_array #(
  parameter int CH    = 4,
  parameter int HYST  = 3,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [CH-1:0]    vip,
  input  logic [CH-1:0]    vin,
  output logic [CH-1:0]    out,
  output logic [CH-1:0]    tie,
  output logic [CH-1:0]    change,
  output logic             out_vld
);

  if (CH < 1 || CH > 8 || HYST < 1 || HYST > 15) begin : g_cfg_err
    $error("digi_ota_array: CH must be 1..8 and HYST 1..15");
  end

  logic [CH-1:0]    vp_m_q, vn_m_q, vp_s_q, vn_s_q;
  logic [DIV_W-1:0] dcnt_q, dcnt_d;
  logic [CH-1:0]    out_q, out_d, tie_q, tie_d, change_q, change_d;
  logic             vld_q;
  logic             tick;

`ifdef DIGI_OTA_HYST_EN
  localparam int HW = $clog2(HYST + 1);
  logic [HW-1:0] hcnt_q [CH];
  logic [HW-1:0] hcnt_d [CH];
`endif

  always_comb begin
    tick     = en && (dcnt_q >= div);
    dcnt_d   = (!en || tick) ? '0 : dcnt_q + 1'b1;
    out_d    = out_q;
    tie_d    = tie_q;
    change_d = '0;
`ifdef DIGI_OTA_HYST_EN
    hcnt_d   = hcnt_q;
`endif
    if (tick) begin
      for (int i = 0; i < CH; i++) begin
        if (vp_s_q[i] == vn_s_q[i]) begin
          // Tie: keep the previous decision and any hysteresis progress.
          tie_d[i] = 1'b1;
        end else begin
          tie_d[i] = 1'b0;
`ifdef DIGI_OTA_HYST_EN
          if (vp_s_q[i] == out_q[i]) begin
            hcnt_d[i] = '0;
          end else if (hcnt_q[i] + HW'(1) == HW'(HYST)) begin
            out_d[i]    = vp_s_q[i];
            change_d[i] = 1'b1;
            hcnt_d[i]   = '0;
          end else begin
            hcnt_d[i] = hcnt_q[i] + HW'(1);
          end
`else
          if (vp_s_q[i] != out_q[i]) begin
            out_d[i]    = vp_s_q[i];
            change_d[i] = 1'b1;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vp_m_q   <= '0;
      vn_m_q   <= '0;
      vp_s_q   <= '0;
      vn_s_q   <= '0;
      dcnt_q   <= '0;
      out_q    <= '0;
      tie_q    <= '0;
      change_q <= '0;
      vld_q    <= 1'b0;
`ifdef DIGI_OTA_HYST_EN
      hcnt_q   <= '{default: '0};
`endif
    end else begin
      vp_m_q   <= vip;
      vn_m_q   <= vin;
      vp_s_q   <= vp_m_q;
      vn_s_q   <= vn_m_q;
      dcnt_q   <= dcnt_d;
      out_q    <= out_d;
      tie_q    <= tie_d;
      change_q <= change_d;
      vld_q    <= tick;
`ifdef DIGI_OTA_HYST_EN
      hcnt_q   <= hcnt_d;
`endif
    end
  end

  assign out     = out_q;
  assign tie     = tie_q;
  assign change  = change_q;
  assign out_vld = vld_q;

endmodule
